// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file with pending-write scoreboard.
// Flat multi-port buses are sliced port-by-port with slice_lo().
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  // Low bit of element idx in a flat bus of w-bit elements.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared by writeback,
// wiped by flush. Bit 0 is always clear. pend_cnt is the registered popcount.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_WR = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_iss_fire,
  input  logic [ADDR_W-1:0]          i_iss_addr,
  input  logic [NUM_WR-1:0]          i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   i_wr_addr,
  input  logic                       i_flush,
  output logic [(2**ADDR_W)-1:0]     o_pend,
  output logic [ADDR_W:0]            o_pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_nxt;
  logic [ADDR_W:0]  r_cnt;
  logic [ADDR_W:0]  w_cnt_nxt;

  // Priority, lowest first: writeback clear, issue set (new producer outstanding), flush.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int w = 0; w < NUM_WR; w++) begin
      if (i_wr_en[w]) w_pend_nxt[i_wr_addr[slice_lo(w, ADDR_W) +: ADDR_W]] = 1'b0;
    end
    if (i_iss_fire) w_pend_nxt[i_iss_addr] = 1'b1;
    if (i_flush) w_pend_nxt = '0;
    w_pend_nxt[REG_ZERO] = 1'b0;
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_pend_nxt[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_pend     = r_pend;
  assign o_pend_cnt = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-first bypass, r0 hardwired to zero, and a
// pending-write scoreboard that raises hazard_o while a consumed operand is outstanding.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  input  logic [NUM_RD-1:0]          rd_use,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic                       hazard_o,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  input  logic                       flush,
  output logic [ADDR_W:0]            pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  w_pend;
  logic              w_iss_fire;

  // Later ports are assigned last, so the highest-index port wins a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[slice_lo(w, ADDR_W) +: ADDR_W] != ADDR_W'(REG_ZERO)))
          r_regs[wr_addr[slice_lo(w, ADDR_W) +: ADDR_W]] <= wr_data[slice_lo(w, DATA_W) +: DATA_W];
      end
    end
  end

  assign w_iss_fire = iss_en && !hazard_o && (iss_addr != ADDR_W'(REG_ZERO));

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_iss_fire (w_iss_fire),
    .i_iss_addr (iss_addr),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_flush    (flush),
    .o_pend     (w_pend),
    .o_pend_cnt (pend_cnt)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_val;

    assign w_ra = rd_addr[slice_lo(p, ADDR_W) +: ADDR_W];

    always_comb begin
      w_val = r_regs[w_ra];
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[slice_lo(w, ADDR_W) +: ADDR_W] == w_ra))
          w_val = wr_data[slice_lo(w, DATA_W) +: DATA_W];
      end
      if (rst || (w_ra == ADDR_W'(REG_ZERO))) w_val = '0;
    end

    assign rd_data[slice_lo(p, DATA_W) +: DATA_W] = w_val;
    // Registered pending state only; a same-cycle writeback is served by the bypass.
    assign rd_busy[p] = !rst && w_pend[w_ra];
  end

  assign hazard_o = (|(rd_busy & rd_use)) && !flush;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (2 read ports, 2 write ports): directed scenarios
// followed by a randomized run against a behavioural reference model.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int D  = 32;

  logic           clk, rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR-1:0]    rd_use;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             hazard_o;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic             flush;
  logic [AW:0]      pend_cnt;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp;

  logic [DW-1:0] m_regs [D];
  logic [D-1:0]  m_pend;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data),
    .rd_busy(rd_busy), .hazard_o(hazard_o), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_addr = '0; rd_use = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    step(); step();
    total++; if (pend_cnt !== 6'd0) begin bad++; $display("FAIL rst_cnt_init: got=%0d exp=0", pend_cnt); end
    total++; if (hazard_o !== 1'b0) begin bad++; $display("FAIL rst_hz_init: got=%b exp=0", hazard_o); end
    rst = 1'b0;
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd5; wr_data[0 +: DW] = 32'hDEADBEEF;
    iss_en = 1'b1; iss_addr = 5'd8;
    step();
    idle();
    rd_addr[0 +: AW] = 5'd5; rd_addr[AW +: AW] = 5'd8; rd_use = 2'b11;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    exp = exp_q.pop_front();
    total++; if (rd_data[0 +: DW] !== exp) begin bad++; $display("FAIL rst_pre_r5: got=%h exp=%h", rd_data[0 +: DW], exp); end
    total++; if (hazard_o !== 1'b1) begin bad++; $display("FAIL rst_pre_hz: got=%b exp=1", hazard_o); end
    total++; if (pend_cnt !== 6'd1) begin bad++; $display("FAIL rst_pre_cnt: got=%0d exp=1", pend_cnt); end
    rst = 1'b1; iss_en = 1'b1; iss_addr = 5'd9;
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    total++; if (rd_data[0 +: DW] !== exp) begin bad++; $display("FAIL rst_r5: got=%h exp=%h", rd_data[0 +: DW], exp); end
    total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL rst_busy: got=%b exp=00", rd_busy); end
    total++; if (hazard_o !== 1'b0) begin bad++; $display("FAIL rst_hz: got=%b exp=0", hazard_o); end
    total++; if (pend_cnt !== 6'd0) begin bad++; $display("FAIL rst_cnt: got=%0d exp=0", pend_cnt); end
    step();
    total++; if (pend_cnt !== 6'd0) begin bad++; $display("FAIL rst_cnt_hold: got=%0d exp=0", pend_cnt); end
    rst = 1'b0; iss_en = 1'b0;
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    total++; if (rd_data[0 +: DW] !== exp) begin bad++; $display("FAIL rst_post_r5: got=%h exp=%h", rd_data[0 +: DW], exp); end
    total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL rst_post_busy: got=%b exp=00", rd_busy); end
    idle();
    step();
  endtask

  task automatic test_bypass();
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd7; wr_data[0 +: DW] = 32'h1234;
    rd_addr[0 +: AW] = 5'd7;
    exp_q.push_back(32'h1234);
    #1;
    exp = exp_q.pop_front();
    total++; if (rd_data[0 +: DW] !== exp) begin bad++; $display("FAIL byp_comb: got=%h exp=%h", rd_data[0 +: DW], exp); end
    step();
    wr_en = '0;
    exp_q.push_back(32'h1234);
    #1;
    exp = exp_q.pop_front();
    total++; if (rd_data[0 +: DW] !== exp) begin bad++; $display("FAIL byp_held: got=%h exp=%h", rd_data[0 +: DW], exp); end
    wr_en = 2'b11; wr_addr = {5'd10, 5'd10}; wr_data = {32'hBBBB_0001, 32'hAAAA_0000};
    rd_addr[AW +: AW] = 5'd10;
    exp_q.push_back(32'hBBBB_0001);
    #1;
    exp = exp_q.pop_front();
    total++; if (rd_data[DW +: DW] !== exp) begin bad++; $display("FAIL byp_prio: got=%h exp=%h", rd_data[DW +: DW], exp); end
    step();
    idle();
    step();
  endtask

  task automatic test_r0();
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd0; wr_data[0 +: DW] = 32'hFFFF_FFFF;
    rd_addr[0 +: AW] = 5'd0;
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    total++; if (rd_data[0 +: DW] !== exp) begin bad++; $display("FAIL r0_comb: got=%h exp=%h", rd_data[0 +: DW], exp); end
    step();
    wr_en = '0; iss_en = 1'b1; iss_addr = 5'd0;
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    total++; if (rd_data[0 +: DW] !== exp) begin bad++; $display("FAIL r0_stored: got=%h exp=%h", rd_data[0 +: DW], exp); end
    step();
    iss_en = 1'b0;
    #1;
    total++; if (pend_cnt !== 6'd0) begin bad++; $display("FAIL r0_iss_cnt: got=%0d exp=0", pend_cnt); end
    total++; if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL r0_busy: got=%b exp=0", rd_busy[0]); end
    idle();
    step();
  endtask

  task automatic test_raw_stall();
    iss_en = 1'b1; iss_addr = 5'd3;
    step();
    iss_en = 1'b1; iss_addr = 5'd11;
    rd_addr[0 +: AW] = 5'd3; rd_use = 2'b01;
    #1;
    total++; if (hazard_o !== 1'b1) begin bad++; $display("FAIL raw_hz: got=%b exp=1", hazard_o); end
    total++; if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL raw_busy: got=%b exp=1", rd_busy[0]); end
    step();
    iss_en = 1'b0;
    #1;
    total++; if (pend_cnt !== 6'd1) begin bad++; $display("FAIL raw_iss_blocked: got=%0d exp=1", pend_cnt); end
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd3; wr_data[0 +: DW] = 32'h55;
    exp_q.push_back(32'h55);
    #1;
    exp = exp_q.pop_front();
    total++; if (rd_data[0 +: DW] !== exp) begin bad++; $display("FAIL raw_bypass: got=%h exp=%h", rd_data[0 +: DW], exp); end
    total++; if (hazard_o !== 1'b1) begin bad++; $display("FAIL raw_hz_wb: got=%b exp=1", hazard_o); end
    step();
    wr_en = '0;
    exp_q.push_back(32'h55);
    #1;
    exp = exp_q.pop_front();
    total++; if (hazard_o !== 1'b0) begin bad++; $display("FAIL raw_hz_clr: got=%b exp=0", hazard_o); end
    total++; if (rd_data[0 +: DW] !== exp) begin bad++; $display("FAIL raw_data: got=%h exp=%h", rd_data[0 +: DW], exp); end
    total++; if (pend_cnt !== 6'd0) begin bad++; $display("FAIL raw_cnt: got=%0d exp=0", pend_cnt); end
    idle();
    step();
  endtask

  task automatic test_collision();
    wr_en = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {32'hB, 32'hA};
    step();
    idle();
    rd_addr[0 +: AW] = 5'd9;
    exp_q.push_back(32'hB);
    #1;
    exp = exp_q.pop_front();
    total++; if (rd_data[0 +: DW] !== exp) begin bad++; $display("FAIL col_data: got=%h exp=%h", rd_data[0 +: DW], exp); end
    iss_en = 1'b1; iss_addr = 5'd9;
    step();
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd9; wr_data[0 +: DW] = 32'hC;
    step();
    idle();
    rd_addr[0 +: AW] = 5'd9;
    #1;
    total++; if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL col_busy: got=%b exp=1", rd_busy[0]); end
    total++; if (pend_cnt !== 6'd1) begin bad++; $display("FAIL col_cnt: got=%0d exp=1", pend_cnt); end
    wr_en = 2'b10; wr_addr[AW +: AW] = 5'd9; wr_data[DW +: DW] = 32'hD;
    step();
    wr_en = '0;
    #1;
    total++; if (pend_cnt !== 6'd0) begin bad++; $display("FAIL col_clear: got=%0d exp=0", pend_cnt); end
    idle();
    step();
  endtask

  task automatic test_flush();
    iss_en = 1'b1; iss_addr = 5'd1; step();
    iss_addr = 5'd2; step();
    iss_addr = 5'd4; step();
    #1;
    total++; if (pend_cnt !== 6'd3) begin bad++; $display("FAIL fl_cnt3: got=%0d exp=3", pend_cnt); end
    iss_addr = 5'd6; flush = 1'b1;
    rd_addr[0 +: AW] = 5'd1; rd_use = 2'b01;
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd12; wr_data[0 +: DW] = 32'h77;
    #1;
    total++; if (hazard_o !== 1'b0) begin bad++; $display("FAIL fl_hz: got=%b exp=0", hazard_o); end
    step();
    idle();
    rd_addr[AW +: AW] = 5'd6; rd_addr[0 +: AW] = 5'd12;
    exp_q.push_back(32'h77);
    #1;
    exp = exp_q.pop_front();
    total++; if (pend_cnt !== 6'd0) begin bad++; $display("FAIL fl_cnt0: got=%0d exp=0", pend_cnt); end
    total++; if (rd_busy[1] !== 1'b0) begin bad++; $display("FAIL fl_r6: got=%b exp=0", rd_busy[1]); end
    total++; if (rd_data[0 +: DW] !== exp) begin bad++; $display("FAIL fl_wr: got=%h exp=%h", rd_data[0 +: DW], exp); end
    step();
  endtask

  task automatic test_random();
    logic [AW-1:0] ra;
    logic [DW-1:0] e;
    logic [NR-1:0] eb;
    logic          ehz;
    logic          fire;
    logic [AW:0]   ec;
    rst = 1'b1; idle(); step();
    rst = 1'b0;
    for (int i = 0; i < D; i++) m_regs[i] = '0;
    m_pend = '0;
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
      rd_use = NR'($urandom_range(0, 3));
      wr_en  = NW'($urandom_range(0, 3));
      for (int w = 0; w < NW; w++) begin
        wr_addr[w*AW +: AW] = AW'($urandom_range(0, 7));
        wr_data[w*DW +: DW] = $urandom;
      end
      iss_en   = ($urandom_range(0, 1) == 1);
      iss_addr = AW'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 15) == 0);
      for (int p = 0; p < NR; p++) begin
        ra = rd_addr[p*AW +: AW];
        e  = m_regs[ra];
        for (int w = 0; w < NW; w++)
          if (wr_en[w] && wr_addr[w*AW +: AW] == ra) e = wr_data[w*DW +: DW];
        if (ra == '0) e = '0;
        exp_q.push_back(e);
        eb[p] = m_pend[ra];
      end
      ehz = (|(eb & rd_use)) && !flush;
      #1;
      for (int p = 0; p < NR; p++) begin
        exp = exp_q.pop_front();
        total++; if (rd_data[p*DW +: DW] !== exp) begin bad++; $display("FAIL rnd_data[%0d] n=%0d: got=%h exp=%h", p, n, rd_data[p*DW +: DW], exp); end
      end
      total++; if (rd_busy !== eb) begin bad++; $display("FAIL rnd_busy n=%0d: got=%b exp=%b", n, rd_busy, eb); end
      total++; if (hazard_o !== ehz) begin bad++; $display("FAIL rnd_hz n=%0d: got=%b exp=%b", n, hazard_o, ehz); end
      fire = iss_en && !ehz && (iss_addr != '0);
      for (int w = 0; w < NW; w++) begin
        if (wr_en[w]) begin
          if (wr_addr[w*AW +: AW] != '0) m_regs[wr_addr[w*AW +: AW]] = wr_data[w*DW +: DW];
          m_pend[wr_addr[w*AW +: AW]] = 1'b0;
        end
      end
      if (fire) m_pend[iss_addr] = 1'b1;
      if (flush) m_pend = '0;
      step();
      ec = (AW+1)'($countones(m_pend));
      total++; if (pend_cnt !== ec) begin bad++; $display("FAIL rnd_cnt n=%0d: got=%0d exp=%0d", n, pend_cnt, ec); end
    end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_r0();
    test_raw_stall();
    test_collision();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
